// File: rtl/fb_write_queue_pkg.sv
// fb_write_queue_pkg: shared framebuffer write types.
// The CDC block, the write queue and the scan-out reader all use these.
// Contents: address/data widths and the packed {addr, data} queue entry.
package fb_write_queue_pkg;

    localparam int FB_ADDR_W = 12;
    localparam int FB_DATA_W = 12;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_entry_t;

endpackage

// File: rtl/fb_write_queue_if.sv
// fb_write_queue_if: write-pulse stream plus framebuffer RAM write port.
// Inputs to the queue:    in_addr, in_data, in_we (single-cycle pulses), fb_busy.
// Outputs from the queue: fb_addr, fb_data, fb_we (registered RAM write).
// master: the producer/RAM side. slave: the queue.
interface fb_write_queue_if;
    import fb_write_queue_pkg::*;

    logic [FB_ADDR_W-1:0] in_addr;
    logic [FB_DATA_W-1:0] in_data;
    logic                 in_we;
    logic                 fb_busy;
    logic [FB_ADDR_W-1:0] fb_addr;
    logic [FB_DATA_W-1:0] fb_data;
    logic                 fb_we;

    modport master (
        output in_addr, in_data, in_we, fb_busy,
        input  fb_addr, fb_data, fb_we
    );

    modport slave (
        input  in_addr, in_data, in_we, fb_busy,
        output fb_addr, fb_data, fb_we
    );

endinterface

// File: rtl/fb_write_queue_fifo_core.sv
// fb_fifo_core: entry storage, pointers and occupancy for the write queue.
// Ports: clk/rst_n (async active-low); push/pop/flush controls;
//        wdata in; head (entry at rd_ptr) out; level, empty, full.
// push and pop must already be qualified by the caller (no push when full
// without pop, no pop when empty). flush takes priority over both.
module fb_fifo_core
    import fb_write_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fb_entry_t        wdata,
    output fb_entry_t        head,
    output logic [PTR_W:0]   level,
    output logic             empty,
    output logic             full
);

    fb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   level_q, level_d;

    // Pointers wrap naturally at PTR_W bits since DEPTH is a power of 2.
    always_comb begin
        rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(push);
        level_d  = flush ? '0 : level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wdata;
    end

    assign head  = mem[rd_ptr_q];
    assign level = level_q;
    assign empty = level_q == '0;
    assign full  = level_q == (PTR_W+1)'(DEPTH);

endmodule

// File: rtl/fb_write_queue.sv
// fb_write_queue: buffers framebuffer write pulses and retires them into the
// RAM write port in cycles where scan-out does not own it.
// Ports: clk_pixel, rst_pixel_n (async active-low);
//        bus (slave): in_addr/in_data/in_we in, fb_busy in, fb_addr/fb_data/fb_we out;
//        flush, clear_ovf in; level, empty, full, overflow, ovf_count out.
module fb_write_queue
    import fb_write_queue_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                clk_pixel,
    input  logic                rst_pixel_n,
    fb_write_queue_if.slave     bus,
    input  logic                flush,
    input  logic                clear_ovf,
    output logic [PTR_W:0]      level,
    output logic                empty,
    output logic                full,
    output logic                overflow,
    output logic [CNT_W-1:0]    ovf_count
);

    localparam int ADDR_W = FB_ADDR_W;
    localparam int DATA_W = FB_DATA_W;

    fb_entry_t         head, wdata;
    logic              pop, push, drop;
    logic              fb_we_q, fb_we_d, overflow_q, overflow_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0] fb_data_q, fb_data_d;
    logic [CNT_W-1:0]  ovf_count_q, ovf_count_d;

    assign wdata = {bus.in_addr, bus.in_data};

    fb_fifo_core #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_core (
        .clk   (clk_pixel),
        .rst_n (rst_pixel_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wdata),
        .head  (head),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    // A full FIFO still accepts a write when the head retires in the same cycle.
    // A drop in the same cycle as clear_ovf wins and restarts the count at 1.
    always_comb begin
        pop         = !empty && !bus.fb_busy && !flush;
        push        = bus.in_we && !flush && (!full || pop);
        drop        = bus.in_we && !flush && full && !pop;
        fb_we_d     = pop;
        fb_addr_d   = pop ? head.addr : fb_addr_q;
        fb_data_d   = pop ? head.data : fb_data_q;
        overflow_d  = drop || (overflow_q && !clear_ovf);
        ovf_count_d = drop ? (clear_ovf ? CNT_W'(1) : (&ovf_count_q ? ovf_count_q : ovf_count_q + 1'b1))
                           : (clear_ovf ? '0 : ovf_count_q);
    end

    always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
        if (!rst_pixel_n) begin
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            overflow_q  <= 1'b0;
            ovf_count_q <= '0;
        end else begin
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            overflow_q  <= overflow_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign bus.fb_we   = fb_we_q;
    assign bus.fb_addr = fb_addr_q;
    assign bus.fb_data = fb_data_q;
    assign overflow    = overflow_q;
    assign ovf_count   = ovf_count_q;

endmodule

// File: tb/tb_fb_write_queue.sv
// tb_fb_write_queue: vector table, corner-case sequences and random traffic against a queue model.
module tb_fb_write_queue;
    import fb_write_queue_pkg::*;

    localparam int DEPTH = 16;

    logic       clk_pixel = 1'b0;
    logic       rst_pixel_n = 1'b0;
    logic       flush = 1'b0;
    logic       clear_ovf = 1'b0;
    logic [4:0] level;
    logic       empty, full, overflow;
    logic [7:0] ovf_count;
    int         errors = 0;
    int         checks = 0;

    fb_write_queue_if bus();

    fb_write_queue dut (
        .clk_pixel   (clk_pixel),
        .rst_pixel_n (rst_pixel_n),
        .bus         (bus),
        .flush       (flush),
        .clear_ovf   (clear_ovf),
        .level       (level),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .ovf_count   (ovf_count)
    );

    always #5 clk_pixel = ~clk_pixel;

    // Reference model: a plain queue of pending writes plus the visible output state.
    logic [23:0] mq[$];
    logic        m_we, m_ovf;
    logic [11:0] m_addr, m_data;
    int          m_cnt;

    typedef struct {
        logic we; logic [11:0] a, d; logic busy, fl, clr;
        logic e_we; logic [11:0] e_a, e_d; int e_lvl;
    } vec_t;
    vec_t vt[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".fb_we"}, bus.fb_we, m_we);
        chk({tag, ".fb_addr"}, bus.fb_addr, m_addr);
        chk({tag, ".fb_data"}, bus.fb_data, m_data);
        chk({tag, ".level"}, level, mq.size());
        chk({tag, ".empty"}, empty, mq.size() == 0);
        chk({tag, ".full"}, full, mq.size() == DEPTH);
        chk({tag, ".overflow"}, overflow, m_ovf);
        chk({tag, ".ovf_count"}, ovf_count, m_cnt);
    endtask

    task automatic model_reset();
        mq.delete();
        m_we = 0; m_addr = 0; m_data = 0; m_ovf = 0; m_cnt = 0;
    endtask

    task automatic step(input string tag, input logic we, input logic [11:0] a, input logic [11:0] d,
                        input logic busy, input logic fl, input logic clr);
        bit popm, dropm;
        bus.in_we = we; bus.in_addr = a; bus.in_data = d; bus.fb_busy = busy;
        flush = fl; clear_ovf = clr;
        popm  = mq.size() > 0 && !busy && !fl;
        dropm = we && !fl && mq.size() == DEPTH && !popm;
        if (fl) begin
            mq.delete();
            m_we = 0;
        end else begin
            m_we = popm;
            if (popm) {m_addr, m_data} = mq.pop_front();
            if (we && !dropm) mq.push_back({a, d});
        end
        if (clr) begin m_ovf = 0; m_cnt = 0; end
        if (dropm) begin m_ovf = 1; m_cnt = m_cnt < 255 ? m_cnt + 1 : 255; end
        @(posedge clk_pixel);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input logic busy);
        step(tag, 1'b0, 12'h0, 12'h0, busy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.in_we = 0; bus.in_addr = 0; bus.in_data = 0; bus.fb_busy = 0;
        flush = 0; clear_ovf = 0;
        rst_pixel_n = 1'b0;
        repeat (2) @(posedge clk_pixel);
        #1;
        model_reset();
        compare_all("reset");
        @(negedge clk_pixel);
        rst_pixel_n = 1'b1;
    endtask

    initial begin
        int pulses;
        logic busy;
        bus.in_we = 0; bus.in_addr = 0; bus.in_data = 0; bus.fb_busy = 0;

        vt[0] = '{1'b1, 12'h123, 12'hABC, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1};
        vt[1] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 12'hABC, 0};
        vt[2] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'hABC, 0};
        vt[3] = '{1'b1, 12'h010, 12'h020, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 12'hABC, 1};
        vt[4] = '{1'b1, 12'h011, 12'h021, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 12'hABC, 2};
        vt[5] = '{1'b1, 12'h012, 12'h022, 1'b0, 1'b1, 1'b0, 1'b0, 12'h123, 12'hABC, 0};
        vt[6] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 12'hABC, 0};
        vt[7] = '{1'b1, 12'h044, 12'h055, 1'b0, 1'b0, 1'b1, 1'b0, 12'h123, 12'hABC, 1};
        vt[8] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 12'h044, 12'h055, 0};

        // Vector table: single-write latency, hold, flush with a write in the flush cycle.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step("vec", vt[i].we, vt[i].a, vt[i].d, vt[i].busy, vt[i].fl, vt[i].clr);
            chk($sformatf("vec%0d.fb_we", i), bus.fb_we, vt[i].e_we);
            chk($sformatf("vec%0d.fb_addr", i), bus.fb_addr, vt[i].e_a);
            chk($sformatf("vec%0d.fb_data", i), bus.fb_data, vt[i].e_d);
            chk($sformatf("vec%0d.level", i), level, vt[i].e_lvl);
        end

        // Stall then drain: 20 writes while busy, 4 of them dropped.
        do_reset();
        for (int k = 0; k < 20; k++) step("stall", 1'b1, 12'(k), 12'(k + 'h100), 1'b1, 1'b0, 1'b0);
        chk("stall.full", full, 1);
        chk("stall.level", level, 16);
        chk("stall.overflow", overflow, 1);
        chk("stall.ovf_count", ovf_count, 4);
        for (int k = 0; k < 16; k++) begin
            idle("drain", 1'b0);
            chk("drain.fb_we", bus.fb_we, 1);
            chk("drain.fb_addr", bus.fb_addr, k);
            chk("drain.fb_data", bus.fb_data, k + 'h100);
        end
        idle("drain_end", 1'b0);
        chk("drain_end.empty", empty, 1);
        chk("drain_end.fb_we", bus.fb_we, 0);

        // Full with simultaneous pop: every write accepted, level pinned at 16.
        do_reset();
        for (int k = 0; k < 16; k++) step("fill", 1'b1, 12'(k), 12'(k), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step("fullpop", 1'b1, 12'(16 + k), 12'(16 + k), 1'b0, 1'b0, 1'b0);
            chk("fullpop.fb_addr", bus.fb_addr, k);
            chk("fullpop.level", level, 16);
            chk("fullpop.ovf_count", ovf_count, 0);
        end

        // Interleaved busy during an 8-entry drain.
        do_reset();
        for (int k = 0; k < 8; k++) step("fill8", 1'b1, 12'(k + 'h40), 12'(k), 1'b1, 1'b0, 1'b0);
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            busy = (i % 2) == 0;
            idle("toggle", busy);
            chk("toggle.fb_we", bus.fb_we, !busy);
            if (bus.fb_we) begin
                chk("toggle.fb_addr", bus.fb_addr, pulses + 'h40);
                pulses++;
            end
        end
        chk("toggle.pulses", pulses, 8);
        chk("toggle.empty", empty, 1);

        // Flush with 5 queued entries stops all retirement.
        do_reset();
        for (int k = 0; k < 5; k++) step("q5", 1'b1, 12'(k), 12'(k), 1'b1, 1'b0, 1'b0);
        step("flush", 1'b0, 12'h0, 12'h0, 1'b0, 1'b1, 1'b0);
        chk("flush.level", level, 0);
        for (int i = 0; i < 3; i++) begin
            idle("postflush", 1'b0);
            chk("postflush.fb_we", bus.fb_we, 0);
        end

        // Clear racing a drop, then saturation.
        do_reset();
        for (int k = 0; k < 16; k++) step("fill", 1'b1, 12'(k), 12'(k), 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) step("drop", 1'b1, 12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b0);
        chk("drop.ovf_count", ovf_count, 3);
        step("clrdrop", 1'b1, 12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b1);
        chk("clrdrop.ovf_count", ovf_count, 1);
        chk("clrdrop.overflow", overflow, 1);
        step("clr", 1'b0, 12'h0, 12'h0, 1'b1, 1'b0, 1'b1);
        chk("clr.ovf_count", ovf_count, 0);
        chk("clr.overflow", overflow, 0);
        for (int k = 0; k < 300; k++) step("sat", 1'b1, 12'hEEE, 12'hEEE, 1'b1, 1'b0, 1'b0);
        chk("sat.ovf_count", ovf_count, 255);
        chk("sat.overflow", overflow, 1);

        // Asynchronous reset between edges while a retire is on the port.
        idle("pre_arst", 1'b0);
        chk("pre_arst.fb_we", bus.fb_we, 1);
        #2;
        rst_pixel_n = 1'b0;
        #1;
        chk("arst.fb_we", bus.fb_we, 0);
        chk("arst.level", level, 0);
        chk("arst.overflow", overflow, 0);
        chk("arst.ovf_count", ovf_count, 0);
        model_reset();
        @(negedge clk_pixel);
        rst_pixel_n = 1'b1;
        step("post_arst0", 1'b1, 12'h5A5, 12'h3C3, 1'b0, 1'b0, 1'b0);
        chk("post_arst0.fb_we", bus.fb_we, 0);
        idle("post_arst1", 1'b0);
        chk("post_arst1.fb_we", bus.fb_we, 1);
        chk("post_arst1.fb_addr", bus.fb_addr, 12'h5A5);
        chk("post_arst1.fb_data", bus.fb_data, 12'h3C3);

        // Random traffic, alternating light and heavy scan-out phases.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int busy_pct;
            busy_pct = ((i / 200) % 2) != 0 ? 90 : 30;
            step("rand", $urandom_range(0, 99) < 70, 12'($urandom), 12'($urandom),
                 $urandom_range(0, 99) < busy_pct, $urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fb_write_queue.md
Name: fb_write_queue

Overview:
- Pixel-domain consumer of the synchronized framebuffer write-pulse stream (addr/data plus a single-cycle we).
- Buffers pulses in a small FIFO and retires them into the framebuffer RAM write port, only in cycles where scan-out does not own the port (fb_busy low).
- Reports fill level and overflow so that CPU-side plotting bursts during active video are never silently corrupted.

Parameters:
- ADDR_W, 12, framebuffer address width
- DATA_W, 12, framebuffer data width
- DEPTH, 16, FIFO entries; must be a power of 2, at least 2
- PTR_W, 4, log2(DEPTH)
- CNT_W, 8, overflow counter width

Ports:
- clk_pixel  in  1  pixel clock (75 MHz); the block's only clock
- rst_pixel_n  in  1  asynchronous, active-low reset
- in_addr  in  ADDR_W  write address, valid when in_we is high
- in_data  in  DATA_W  write data, valid when in_we is high
- in_we  in  1  single-cycle write pulse; back-to-back pulses are legal
- flush  in  1  synchronous discard of all queued entries
- fb_busy  in  1  scan-out owns the RAM port this cycle; no pop allowed
- clear_ovf  in  1  synchronous clear of overflow and ovf_count
- fb_addr  out  ADDR_W  RAM write address, registered
- fb_data  out  DATA_W  RAM write data, registered
- fb_we  out  1  RAM write strobe, registered, one cycle per entry
- level  out  PTR_W+1  current occupancy, 0..DEPTH
- empty  out  1  level == 0
- full  out  1  level == DEPTH
- overflow  out  1  sticky: at least one write was dropped
- ovf_count  out  CNT_W  dropped-write count, saturates at all-ones

Behaviour:
Reset (asynchronous, any time, including mid-drain):
- rd_ptr, wr_ptr and level go to 0; empty=1, full=0.
- fb_we=0, fb_addr=0, fb_data=0.
- overflow=0, ovf_count=0.
- Storage array is not reset; its contents are don't-care.

Pop:
- pop = !empty & !fb_busy & !flush, evaluated on registered state.
- On a pop edge: fb_addr/fb_data <= head entry, fb_we <= 1, rd_ptr++.
- Otherwise fb_we <= 0; fb_addr/fb_data hold their last value.

Push:
- push = in_we & !flush & (!full | pop).
- A push into a full FIFO is accepted when a pop happens in the same cycle.
- On a push: mem[wr_ptr] <= {in_addr, in_data}, wr_ptr++.

Level update:
- push only: +1. Pop only: -1. Both: unchanged.

Pointers:
- PTR_W bits wide; wrap modulo DEPTH.
- full/empty come from the level register, not from pointer comparison.

Drop:
- Occurs when in_we & !flush & full & !pop.
- Entry is discarded; overflow <= 1; ovf_count++ saturating at 2^CNT_W-1.

Overflow clear:
- clear_ovf zeroes overflow and ovf_count.
- If a drop occurs in the same cycle, the drop wins: overflow=1, ovf_count=1.

Flush:
- Next edge: rd_ptr=wr_ptr=0, level=0, fb_we=0.
- An in_we in the flush cycle is discarded and is not counted as a drop.
- Overflow state is untouched.

Latency and ordering:
- in_we at edge N with the FIFO empty and fb_busy low -> fb_we high after edge N+1 (one cycle of queueing, one cycle of output register).
- Strict FIFO order; no address coalescing. Two writes to the same address both retire, last one wins.

Throughput:
- One retire per non-busy cycle.
- fb_busy held high stalls retirement indefinitely; only push or drop activity continues.

Decomposition:
- Shared package: FB_ADDR_W=12, FB_DATA_W=12, fb_entry_t = {addr, data} packed struct. The same package serves the CDC block and the scan-out reader.
- One natural sub-module: fb_fifo_core (storage, pointers, level, full/empty; push/pop in, head out).
- Top level adds the pop arbitration, output register and overflow logic.

Test Plan:
- Single write: in_we addr=0x123 data=0xABC with fb_busy=0 -> fb_we high exactly 2 edges later with fb_addr=0x123, fb_data=0xABC; level returns to 0.
- Stall and drain: fb_busy=1, 20 back-to-back writes (addr=k, data=k+0x100, k=0..19):
  - -> full=1 and level=16; overflow=1, ovf_count=4.
  - After fb_busy=0 -> 16 consecutive fb_we cycles with addr 0..15 in order, then empty=1.
- Full with simultaneous pop: FIFO full, fb_busy=0, in_we each cycle -> no drops (ovf_count unchanged), level stays 16, order preserved.
- Interleaved busy: fb_busy toggles 1/0 each cycle during an 8-entry drain -> fb_we only in the cycle after each fb_busy=0 cycle, 8 pulses total, data in order.
- Flush and clear:
  - 5 entries queued, flush pulse -> no further fb_we; level=0.
  - clear_ovf together with a drop -> ovf_count=1, overflow=1.
  - 300 drops -> ovf_count=255.
- Async reset mid-drain: assert rst_pixel_n low between clock edges while fb_we=1 -> fb_we, level and overflow go to 0 immediately. After release, a single write again retires with latency 2.
